// File: rtl/m68k_bus_master.sv
// 68000-style bus initiator: runs single read/write cycles for an internal engine.
// Optional self-timeout on WAIT is enabled with `define BUS_TIMEOUT_EN.
module m68k_bus_master #(
  parameter int ADDR_WIDTH     = 23,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  Clk,
  input  logic                  Reset_L,
  input  logic                  Req_H,
  input  logic                  ReqRnW_H,
  input  logic [ADDR_WIDTH-1:0] ReqAddr,
  input  logic [DATA_WIDTH-1:0] ReqWData,
  input  logic                  ReqUDS_H,
  input  logic                  ReqLDS_H,
  output logic                  Busy_H,
  output logic                  Ack_H,
  output logic                  Err_H,
  output logic [DATA_WIDTH-1:0] RData,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  DataOutEn_H,
  output logic                  RW,
  output logic                  AS_L,
  output logic                  UDS_L,
  output logic                  LDS_L,
  input  logic [DATA_WIDTH-1:0] DataIn,
  input  logic                  DtackIn_L,
  input  logic                  BerrIn_L
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ASSERT, S_WAIT, S_RELEASE, S_RECOVER
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    doe_q, doe_d;
  logic                    rw_q, rw_d;
  logic                    as_q, as_d;
  logic                    uds_q, uds_d;
  logic                    lds_q, lds_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;
  logic                    enu_q, enu_d;
  logic                    enl_q, enl_d;
  logic                    dtack_q, berr_q;

`ifdef BUS_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  // Responder inputs are asynchronous to us; every decision uses the registered copy.
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      dtack_q <= 1'b1;
      berr_q  <= 1'b1;
    end else begin
      dtack_q <= DtackIn_L;
      berr_q  <= BerrIn_L;
    end
  end

  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      doe_q   <= 1'b0;
      rw_q    <= 1'b1;
      as_q    <= 1'b1;
      uds_q   <= 1'b1;
      lds_q   <= 1'b1;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      enu_q   <= 1'b0;
      enl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      doe_q   <= doe_d;
      rw_q    <= rw_d;
      as_q    <= as_d;
      uds_q   <= uds_d;
      lds_q   <= lds_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      enu_q   <= enu_d;
      enl_q   <= enl_d;
    end
  end

`ifdef BUS_TIMEOUT_EN
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`endif

  // Outputs are computed for the state being entered, so they change on the same edge as the state.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    doe_d   = doe_q;
    rw_d    = rw_q;
    as_d    = as_q;
    uds_d   = uds_q;
    lds_d   = lds_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    busy_d  = busy_q;
    enu_d   = enu_q;
    enl_d   = enl_q;
`ifdef BUS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (Req_H) begin
          state_d = S_ADDR;
          addr_d  = ReqAddr;
          dout_d  = ReqWData;
          rw_d    = ReqRnW_H;
          doe_d   = !ReqRnW_H;
          busy_d  = 1'b1;
          // No byte enabled is treated as a full-word access.
          enu_d   = ReqUDS_H || !(ReqUDS_H || ReqLDS_H);
          enl_d   = ReqLDS_H || !(ReqUDS_H || ReqLDS_H);
        end
      end
      S_ADDR: begin
        state_d = S_ASSERT;
        as_d    = 1'b0;
        if (rw_q) begin
          uds_d = !enu_q;
          lds_d = !enl_q;
        end
      end
      S_ASSERT: begin
        state_d = S_WAIT;
        uds_d   = !enu_q;
        lds_d   = !enl_q;
`ifdef BUS_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (!berr_q) begin
          state_d = S_RELEASE;
          err_d   = 1'b1;
        end else if (!dtack_q) begin
          state_d = S_RELEASE;
          ack_d   = 1'b1;
          if (rw_q) rdata_d = DataIn;
`ifdef BUS_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT_CYCLES)) begin
          state_d = S_RELEASE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
        if (state_d == S_RELEASE) begin
          as_d  = 1'b1;
          uds_d = 1'b1;
          lds_d = 1'b1;
          doe_d = 1'b0;
        end
      end
      S_RELEASE: begin
        state_d = S_RECOVER;
      end
      S_RECOVER: begin
        // Hold off until the responder has withdrawn DTACK/BERR from this cycle.
        if (dtack_q && berr_q) begin
          state_d = S_IDLE;
          rw_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        as_d    = 1'b1;
        uds_d   = 1'b1;
        lds_d   = 1'b1;
        doe_d   = 1'b0;
        rw_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign Busy_H      = busy_q;
  assign Ack_H       = ack_q;
  assign Err_H       = err_q;
  assign RData       = rdata_q;
  assign Address     = addr_q;
  assign DataOut     = dout_q;
  assign DataOutEn_H = doe_q;
  assign RW          = rw_q;
  assign AS_L        = as_q;
  assign UDS_L       = uds_q;
  assign LDS_L       = lds_q;

endmodule

// File: tb/tb_m68k_bus_master.sv
// Scoreboard bench for m68k_bus_master with a simple DTACK/BERR responder model.
module tb_m68k_bus_master;
  localparam int AW = 23;
  localparam int DW = 16;
  localparam int TO = 10;

  logic          Clk = 1'b0;
  logic          Reset_L = 1'b0;
  logic          Req_H = 1'b0, ReqRnW_H = 1'b1, ReqUDS_H = 1'b0, ReqLDS_H = 1'b0;
  logic [AW-1:0] ReqAddr = '0;
  logic [DW-1:0] ReqWData = '0;
  logic          Busy_H, Ack_H, Err_H, DataOutEn_H, RW, AS_L, UDS_L, LDS_L;
  logic [DW-1:0] RData, DataOut;
  logic [AW-1:0] Address;
  logic [DW-1:0] DataIn = '0;
  logic          DtackIn_L, BerrIn_L;

  m68k_bus_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .Clk(Clk), .Reset_L(Reset_L), .Req_H(Req_H), .ReqRnW_H(ReqRnW_H),
    .ReqAddr(ReqAddr), .ReqWData(ReqWData), .ReqUDS_H(ReqUDS_H), .ReqLDS_H(ReqLDS_H),
    .Busy_H(Busy_H), .Ack_H(Ack_H), .Err_H(Err_H), .RData(RData), .Address(Address),
    .DataOut(DataOut), .DataOutEn_H(DataOutEn_H), .RW(RW), .AS_L(AS_L), .UDS_L(UDS_L),
    .LDS_L(LDS_L), .DataIn(DataIn), .DtackIn_L(DtackIn_L), .BerrIn_L(BerrIn_L)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Responder: DTACK resp_wait clocks after AS_L falls, optionally held hold_clks after AS_L rises.
  logic resp_on = 1'b0, berr_mode = 1'b0;
  int   resp_wait = 0, hold_clks = 0, as_cnt = 0, hold_cnt = 0;
  always @(posedge Clk) begin
    as_cnt   <= AS_L ? 0 : as_cnt + 1;
    hold_cnt <= !AS_L ? hold_clks : (hold_cnt != 0 ? hold_cnt - 1 : 0);
  end
  assign DtackIn_L = !(resp_on && ((!AS_L && as_cnt >= resp_wait) || (AS_L && hold_cnt != 0)));
  assign BerrIn_L  = !(berr_mode && !AS_L);

  typedef struct {
    logic          ack;
    logic          err;
    logic [DW-1:0] rdata;
    int            at;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (Reset_L && (Ack_H || Err_H)) begin
      exp_t e;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp: got ack=%0b err=%0b expected none", Ack_H, Err_H);
      end else begin
        e = sb.pop_front();
        chk("resp_ack", 32'(Ack_H), 32'(e.ack));
        chk("resp_err", 32'(Err_H), 32'(e.err));
        chk("resp_rdata", 32'(RData), 32'(e.rdata));
        chk("resp_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic req(input logic rnw, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                     input logic u, input logic l, output int acc);
    @(negedge Clk);
    ReqRnW_H = rnw; ReqAddr = a; ReqWData = wd; ReqUDS_H = u; ReqLDS_H = l; Req_H = 1'b1;
    @(negedge Clk);
    Req_H = 1'b0;
    acc = cyc;
  endtask

  task automatic push(input logic ack, input logic err, input logic [DW-1:0] rd, input int at);
    exp_t e;
    e.ack = ack; e.err = err; e.rdata = rd; e.at = at;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (Busy_H && n < maxc) begin
      @(negedge Clk);
      n++;
    end
    chk("idle_reached", 32'(Busy_H), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    repeat (2) @(negedge Clk);
    chk("rst_strobes", {28'h0, AS_L, UDS_L, LDS_L, RW}, 32'hF);
    chk("rst_flags", {28'h0, DataOutEn_H, Busy_H, Ack_H, Err_H}, 32'h0);
    chk("rst_data", 32'(Address) | 32'(DataOut) | 32'(RData), 32'h0);
    Reset_L = 1'b1;

    // Zero-wait read
    resp_on = 1'b1; resp_wait = 0; DataIn = 16'hBEEF;
    req(1'b1, 23'h001000, 16'h0, 1'b1, 1'b1, acc);
    push(1'b1, 1'b0, 16'hBEEF, acc + 3);
    chk("rd_addr_phase", {27'h0, AS_L, Busy_H, RW, DataOutEn_H, 1'b0}, 32'h1C);
    chk("rd_address", 32'(Address), 32'h001000);
    @(negedge Clk);
    chk("rd_assert_strobes", {29'h0, AS_L, UDS_L, LDS_L}, 32'h0);
    repeat (3) @(negedge Clk);
    chk("rd_busy_before_idle", 32'(Busy_H), 32'h1);
    @(negedge Clk);
    chk("rd_busy_idle", 32'(Busy_H), 32'h0);

    // Write, lower byte only, DTACK three clocks after AS_L
    resp_wait = 3;
    req(1'b0, 23'h000200, 16'h00A5, 1'b0, 1'b1, acc);
    push(1'b1, 1'b0, 16'hBEEF, acc + 6);
    chk("wr_addr_phase", {29'h0, DataOutEn_H, RW, AS_L}, 32'h5);
    chk("wr_dataout", 32'(DataOut), 32'h00A5);
    @(negedge Clk);
    chk("wr_assert_strobes", {29'h0, AS_L, UDS_L, LDS_L}, 32'h3);
    @(negedge Clk);
    chk("wr_wait_strobes", {28'h0, DataOutEn_H, AS_L, UDS_L, LDS_L}, 32'hA);
    repeat (3) @(negedge Clk);
    chk("wr_wait_late", {28'h0, DataOutEn_H, AS_L, UDS_L, LDS_L}, 32'hA);
    @(negedge Clk);
    chk("wr_release", {28'h0, DataOutEn_H, AS_L, UDS_L, LDS_L}, 32'h7);
    wait_idle(20);
    resp_wait = 0;

    // Bus error with DTACK also low; no enables means both bytes
    berr_mode = 1'b1; DataIn = 16'h1234;
    req(1'b1, 23'h0ABCDE, 16'h0, 1'b0, 1'b0, acc);
    push(1'b0, 1'b1, 16'hBEEF, acc + 3);
    @(negedge Clk);
    chk("berr_both_bytes", {30'h0, UDS_L, LDS_L}, 32'h0);
    wait_idle(20);
    berr_mode = 1'b0;

    // DTACK held after release; a request during RECOVER is dropped
    DataIn = 16'h5A5A; hold_clks = 5;
    req(1'b1, 23'h000010, 16'h0, 1'b1, 1'b1, acc);
    push(1'b1, 1'b0, 16'h5A5A, acc + 3);
    repeat (5) @(negedge Clk);
    ReqAddr = 23'h7FFFFF; Req_H = 1'b1;
    @(negedge Clk);
    Req_H = 1'b0;
    repeat (3) @(negedge Clk);
    chk("hold_busy", 32'(Busy_H), 32'h1);
    @(negedge Clk);
    chk("hold_idle", 32'(Busy_H), 32'h0);
    repeat (2) @(negedge Clk);
    chk("hold_req_dropped", {30'h0, Busy_H, AS_L}, 32'h1);
    hold_clks = 0;

    // Reset in WAIT
    resp_on = 1'b0;
    req(1'b0, 23'h000300, 16'hFFFF, 1'b1, 1'b1, acc);
    repeat (3) @(negedge Clk);
    chk("mid_wait_strobes", {28'h0, DataOutEn_H, AS_L, UDS_L, LDS_L}, 32'h8);
    #2 Reset_L = 1'b0;
    #1 chk("mid_rst_async", {28'h0, DataOutEn_H, AS_L, UDS_L, LDS_L}, 32'h7);
    @(negedge Clk);
    Reset_L = 1'b1;
    @(negedge Clk);
    chk("mid_rst_idle", {30'h0, Busy_H, RW}, 32'h1);

    // Unanswered cycle
    req(1'b1, 23'h000400, 16'h0, 1'b1, 1'b1, acc);
`ifdef BUS_TIMEOUT_EN
    push(1'b0, 1'b1, 16'h0, acc + 13);
    wait_idle(40);
`else
    begin
      int drops = 0;
      repeat (1000) begin
        @(negedge Clk);
        if (!Busy_H) drops++;
      end
      chk("busy_held_1000", 32'(drops), 32'h0);
    end
    Reset_L = 1'b0;
    @(negedge Clk);
    Reset_L = 1'b1;
`endif

    repeat (3) @(negedge Clk);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
